// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: merges pipeline writebacks with buffered auxiliary writes
// into a single registered regfile write port. Pipeline writes have priority.
// Aux writes wait in a small FIFO. A newer pipeline write to the same rd
// kills any buffered entry for that rd.
// Optional feature: define WB_BYPASS_EN to let an aux write issue directly
// when the unit is idle.
module reg_wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic                          clk,
  input  logic                          Rst,
  input  logic                          mem_hold,
  input  logic                          pipe_wen,
  input  logic [4:0]                    pipe_rd,
  input  logic [XLEN-1:0]               pipe_data,
  input  logic                          aux_valid,
  output logic                          aux_ready,
  input  logic [4:0]                    aux_rd,
  input  logic [XLEN-1:0]               aux_data,
  output logic                          MEM_WB_regwrite,
  output logic [4:0]                    MEM_WB_rd,
  output logic [XLEN-1:0]               WB_res,
  output logic [31:0]                   pend_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [4:0]            ent_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]       ent_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [AW-1:0]         head, tail;
  logic [CW-1:0]         count;

  logic aux_acc, pipe_iss, fifo_pop, byp, push;

  // Issue decisions for this cycle; all use pre-pop occupancy.
  always_comb begin
    aux_ready = (count < DEPTH_C) && !Rst;
    aux_acc   = aux_valid && aux_ready && (aux_rd != 5'd0);
    pipe_iss  = !mem_hold && pipe_wen && (pipe_rd != 5'd0);
    fifo_pop  = !mem_hold && !pipe_iss && (count != '0);
`ifdef WB_BYPASS_EN
    byp       = !mem_hold && !pipe_iss && (count == '0) && aux_acc;
`else
    byp       = 1'b0;
`endif
    push      = aux_acc && !byp;
  end

  // FIFO storage: kill matching entries, pop head, push new tail.
  always_ff @(posedge clk) begin
    if (Rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (pipe_iss && ent_vld[i] && (ent_rd[i] == pipe_rd))
          ent_vld[i] <= 1'b0;
      if (fifo_pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      // A push never lands on the head slot being popped: count>0 and
      // count<depth implies tail != head.
      if (push) begin
        ent_rd[tail]   <= aux_rd;
        ent_data[tail] <= aux_data;
        ent_vld[tail]  <= 1'b1;
        tail           <= tail + 1'b1;
      end
      case ({push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered regfile write port; frozen entirely while mem_hold is high.
  always_ff @(posedge clk) begin
    if (Rst) begin
      MEM_WB_regwrite <= 1'b0;
      MEM_WB_rd       <= '0;
      WB_res          <= '0;
    end else if (!mem_hold) begin
      if (pipe_iss) begin
        MEM_WB_regwrite <= 1'b1;
        MEM_WB_rd       <= pipe_rd;
        WB_res          <= pipe_data;
      end else if (fifo_pop) begin
        // A killed head still consumes its slot but writes nothing.
        MEM_WB_regwrite <= ent_vld[head];
        if (ent_vld[head]) begin
          MEM_WB_rd <= ent_rd[head];
          WB_res    <= ent_data[head];
        end
      end else if (byp) begin
        MEM_WB_regwrite <= 1'b1;
        MEM_WB_rd       <= aux_rd;
        WB_res          <= aux_data;
      end else begin
        MEM_WB_regwrite <= 1'b0;
      end
    end
  end

  // Pending-rd mask from live buffered entries; x0 is never pending.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_vld[i]) pend_mask[ent_rd[i]] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  assign fifo_count = count;

endmodule
